// File: rtl/mmio_pkg.sv
// mmio_pkg: region codes, register offsets, error bit indices and timebase constants for mmio_bridge
package mmio_pkg;
  localparam logic [11:0] REG_VGA = 12'h201;
  localparam logic [11:0] REG_KBD = 12'h202;
  localparam logic [11:0] REG_LED = 12'h203;
  localparam logic [11:0] REG_HEX = 12'h204;
  localparam logic [11:0] REG_CLK = 12'h205;
  localparam logic [11:0] REG_SW  = 12'h206;
  localparam logic [11:0] REG_ERR = 12'h207;
  typedef enum logic [1:0] {OFF_DATA = 2'd0} single_off_e;
  typedef enum logic [1:0] {KBD_POP = 2'd0, KBD_STAT = 2'd1} kbd_off_e;
  typedef enum logic [1:0] {CLK_S = 2'd0, CLK_MS = 2'd1, CLK_US = 2'd2, CLK_CMP = 2'd3} clk_off_e;
  typedef enum logic [1:0] {ERR_FLAGS = 2'd0, ERR_ADDR = 2'd1} err_off_e;
  localparam int ERR_RD = 0;
  localparam int ERR_WR = 1;
  localparam int US_PER_MS = 1000;
  localparam int MS_PER_S = 1000;
endpackage

// File: rtl/mmio_kbd_fifo.sv
// mmio_kbd_fifo: scan-code FIFO; a push while full is dropped unless a pop frees a slot that same cycle
//   clk/clr: clock, sync active-high reset; push/din: write side; pop/dout: read side (dout shows head)
//   count/full/empty: occupancy status
module mmio_kbd_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU MMIO decode for LED, 7-seg, VGA line, switches, keyboard FIFO, us/ms/s counters and error capture
//   clk/clr: clock, sync active-high reset; addr/re/we/wdata -> rdata: CPU data port, rdata registered
//   kbd_code/kbd_valid: scan-code strobe; sw: switches; led/hex/vga_line: output registers
//   err_irq: any error flag set; timer_irq: clk_ms compare match, only when MMIO_TIMER_CMP_EN is defined
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int KBD_DEPTH = 16,
  parameter int LED_W = 16,
  parameter int SW_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [7:0]        kbd_code,
  input  logic              kbd_valid,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic [31:0]       hex,
  output logic [31:0]       vga_line,
  output logic              err_irq,
  output logic              timer_irq
);
  localparam int CW = $clog2(KBD_DEPTH) + 1;
  localparam logic [31:0] DIV_M1 = 32'(CLK_HZ / 1000000 - 1);
  logic [11:0] region;
  logic [1:0] off;
  logic rd_ok, wr_ok;
  logic [31:0] rd_val;
  logic kbd_pop, kbd_full, kbd_empty, kbd_ovf;
  logic [7:0] kbd_dout;
  logic [CW-1:0] kbd_count;
  logic [31:0] clk_s, clk_ms, clk_us, pre_us, cmp;
  logic [9:0] pre_ms, pre_s;
  logic us_tick, ms_tick, s_tick, clk_clr, err_clr;
  logic [1:0] flags, flags_nxt, new_err;
  logic [31:0] err_addr;
  logic unused_addr;
  assign region = addr[31:20];
  assign off = addr[3:2];
  assign unused_addr = ^{addr[19:4], addr[1:0]};
  assign kbd_pop = re && region == REG_KBD && off == KBD_POP;
  assign clk_clr = we && region == REG_CLK && off != CLK_CMP;
  assign err_clr = we && region == REG_ERR && off == ERR_FLAGS;
  assign us_tick = pre_us == DIV_M1;
  assign ms_tick = us_tick && pre_ms == 10'(US_PER_MS - 1);
  assign s_tick = ms_tick && pre_s == 10'(MS_PER_S - 1);
`ifdef MMIO_TIMER_CMP_EN
  localparam bit CMP_EN = 1'b1;
  always_ff @(posedge clk) begin
    if (clr) begin
      cmp <= '0;
      timer_irq <= 1'b0;
    end else if (we && region == REG_CLK && off == CLK_CMP) begin
      cmp <= wdata;
      timer_irq <= 1'b0;
    end else if (ms_tick && !clk_clr && clk_ms + 32'd1 == cmp) begin
      timer_irq <= 1'b1;
    end
  end
`else
  localparam bit CMP_EN = 1'b0;
  assign cmp = '0;
  assign timer_irq = 1'b0;
`endif
  always_comb begin
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    rd_val = '0;
    case (region)
      REG_VGA: begin
        rd_ok = off == OFF_DATA;
        wr_ok = rd_ok;
        rd_val = vga_line;
      end
      REG_KBD: begin
        rd_ok = off == KBD_POP || off == KBD_STAT;
        wr_ok = off == KBD_STAT;
        rd_val = off == KBD_STAT ? {16'b0, kbd_ovf, 7'b0, 8'(kbd_count)} : kbd_empty ? '0 : {23'b0, 1'b1, kbd_dout};
      end
      REG_LED: begin
        rd_ok = off == OFF_DATA;
        wr_ok = rd_ok;
        rd_val = 32'(led);
      end
      REG_HEX: begin
        rd_ok = off == OFF_DATA;
        wr_ok = rd_ok;
        rd_val = hex;
      end
      REG_CLK: begin
        rd_ok = off != CLK_CMP || CMP_EN;
        wr_ok = rd_ok;
        rd_val = off == CLK_S ? clk_s : off == CLK_MS ? clk_ms : off == CLK_US ? clk_us : cmp;
      end
      REG_SW: begin
        rd_ok = off == OFF_DATA;
        rd_val = 32'(sw);
      end
      REG_ERR: begin
        rd_ok = off == ERR_FLAGS || off == ERR_ADDR;
        wr_ok = rd_ok;
        rd_val = off == ERR_FLAGS ? {30'b0, flags} : err_addr;
      end
      default: ;
    endcase
  end
  assign new_err[ERR_RD] = re && !rd_ok;
  assign new_err[ERR_WR] = we && !wr_ok;
  // a clear and a fresh error on the same edge leave the fresh error standing
  assign flags_nxt = (err_clr ? 2'b00 : flags) | new_err;
  mmio_kbd_fifo #(.DEPTH(KBD_DEPTH), .W(8)) u_kbd (
    .clk(clk),
    .clr(clr),
    .push(kbd_valid),
    .din(kbd_code),
    .pop(kbd_pop),
    .dout(kbd_dout),
    .count(kbd_count),
    .full(kbd_full),
    .empty(kbd_empty)
  );
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
      led <= '0;
      hex <= '0;
      vga_line <= '0;
      kbd_ovf <= 1'b0;
      flags <= '0;
      err_addr <= '0;
      err_irq <= 1'b0;
    end else begin
      if (re) rdata <= rd_ok ? rd_val : '0;
      if (wr_ok && we && region == REG_LED) led <= wdata[LED_W-1:0];
      if (wr_ok && we && region == REG_HEX) hex <= wdata;
      if (wr_ok && we && region == REG_VGA) vga_line <= wdata;
      kbd_ovf <= (we && region == REG_KBD && off == KBD_STAT ? 1'b0 : kbd_ovf) | (kbd_valid && kbd_full && !kbd_pop);
      flags <= flags_nxt;
      err_irq <= |flags_nxt;
      if (|new_err && (flags == '0 || err_clr)) err_addr <= addr;
      else if (err_clr) err_addr <= '0;
    end
  end
  always_ff @(posedge clk) begin
    if (clr || clk_clr) begin
      pre_us <= '0;
      pre_ms <= '0;
      pre_s <= '0;
      clk_us <= '0;
      clk_ms <= '0;
      clk_s <= '0;
    end else begin
      pre_us <= us_tick ? '0 : pre_us + 32'd1;
      if (us_tick) begin
        clk_us <= clk_us + 32'd1;
        pre_ms <= ms_tick ? '0 : pre_ms + 10'd1;
      end
      if (ms_tick) begin
        clk_ms <= clk_ms + 32'd1;
        pre_s <= s_tick ? '0 : pre_s + 10'd1;
      end
      if (s_tick) clk_s <= clk_s + 32'd1;
    end
  end
endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
Memory-mapped I/O bridge between the single-cycle CPU data port and the board peripherals: LED, 7-segment digits, VGA line register, switches, keyboard and time counters.
- Decodes addr[31:20] into regions.
- Buffers keyboard scan codes in a FIFO.
- Generates us/ms/s counters from one clock.
- Records invalid accesses in sticky error registers.
Data memory remains external; the top-level selects between data_mem and rdata by region.

Parameters:
CLK_HZ, 50000000, clk frequency; must be a multiple of 1000000.
KBD_DEPTH, 16, keyboard FIFO entries; power of two, >= 2.
LED_W, 16, LED output width (1..32).
SW_W, 16, switch input width (1..32).

Ports:
clk  in  1  system clock; all state on posedge.
clr  in  1  synchronous active-high reset.
addr  in  32  CPU data address.
re  in  1  read strobe.
we  in  1  write strobe.
wdata  in  32  write data.
rdata  out  32  read data, registered.
kbd_code  in  8  scan code from keyboard block.
kbd_valid  in  1  one-cycle strobe; pushes kbd_code.
sw  in  SW_W  switch levels.
led  out  LED_W  LED register.
hex  out  32  eight 4-bit digits; digit i = hex[4i+3:4i].
vga_line  out  32  VGA line register.
err_irq  out  1  high while any error flag is set.
timer_irq  out  1  compare-match flag; see Optional Feature.

Behaviour:
- Reset (clr=1 on a posedge):
  - rdata, led, hex, vga_line, all counters, prescalers, FIFO pointers, error flags and err_addr go to 0.
  - err_irq and timer_irq are 0 on the following cycle.
  - A reset mid-access discards the access; a reset mid-prescale restarts the prescale.
- Region = addr[31:20], offset = addr[3:2]:
  - VGA_LINE 0x201 (off 0).
  - KBD 0x202 (off 0 pop, off 1 status).
  - LED 0x203 (off 0).
  - HEX 0x204 (off 0).
  - CLK 0x205 (off 0 s, 1 ms, 2 us, 3 cmp).
  - SW 0x206 (off 0).
  - ERR 0x207 (off 0 flags, off 1 err_addr).
  - Any other region or offset is invalid.
- Reads:
  - When re=1, rdata is updated on that posedge (valid the next cycle); rdata holds when re=0.
  - Data format:
    - LED reads {zero-pad, led}.
    - SW reads {zero-pad, sw}, sampled at the read edge.
    - KBD off 0 reads {23'b0, 1, code} and pops; on empty it reads 0 and does not pop.
    - KBD off 1 reads {16'b0, overflow, 7'b0, count}; count is $clog2(KBD_DEPTH)+1 bits, zero-extended.
- Writes:
  - When we=1, the target register loads on the posedge.
  - led <= wdata[LED_W-1:0]; hex <= wdata; vga_line <= wdata.
  - Write to KBD off 1 clears overflow. Write to CLK off 0..2 zeroes all three counters and both prescalers. Write to ERR off 0 clears flags and err_addr.
  - Writes to KBD off 0 and SW are invalid.
- re and we in the same cycle: both are performed. rdata returns the pre-write value of the target.
- FIFO:
  - Push on kbd_valid.
  - When full with no pop, the code is dropped and overflow is set (sticky).
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push and pop in the same cycle while empty: the push lands, the read returns 0 (no bypass).
  - Pointers wrap modulo KBD_DEPTH.
- Counters:
  - Prescaler counts 0..CLK_HZ/1000000-1; each wrap increments clk_us.
  - A second prescaler counts us ticks 0..999; each wrap increments clk_ms.
  - A third counts ms ticks 0..999; each wrap increments clk_s.
  - All counters are 32-bit and wrap to 0 silently.
- Errors:
  - rd_err (bit 0) is set on an invalid read; wr_err (bit 1) on an invalid write. Both are sticky.
  - An invalid read returns 0.
  - err_addr captures addr of the first error only (when flags==0).
  - err_irq = |flags, registered.
  - If a clear of ERR and a new error occur in the same cycle, the new error wins.

Optional Feature:
MMIO_TIMER_CMP_EN.
- Defined:
  - CLK off 3 is a read/write 32-bit compare register, reset 0.
  - When clk_ms transitions to a value equal to cmp, timer_irq is set on the same edge as the increment.
  - timer_irq is sticky; any write to CLK off 3 clears it.
  - A reset to 0 does not fire.
- Undefined: CLK off 3 is invalid and timer_irq is tied 0.

Decomposition:
- Package mmio_pkg holds:
  - region codes (12-bit localparams);
  - offset enums per region;
  - ERR bit indices;
  - US_PER_MS/MS_PER_S = 1000.
- One sub-module, mmio_kbd_fifo (params DEPTH, W=8; ports clk, clr, push, din, pop, dout, count, full, empty), instantiated for the keyboard buffer.

Test Plan:
- clr then 50000 idle cycles (CLK_HZ=50e6) -> CLK off 2 reads 1000, off 1 reads 1, off 0 reads 0. At 50e6 cycles, off 0 reads 1.
- Write 0x0000A5A5 to 0x20300000, then read it back -> led=16'hA5A5. rdata=0x0000A5A5 exactly one cycle after re.
- Push 17 codes 0x10..0x20 with KBD_DEPTH=16 -> status reads count=16, overflow=1. Pops yield 0x110..0x11F, then 0.
- Read 0x2FF00000, then write 0x20600000 -> flags=2'b11, err_addr=0x2FF00000, err_irq=1. Write to ERR -> flags 0, err_irq 0 the next cycle.
- With MMIO_TIMER_CMP_EN: write cmp=3, wait 3 ms -> timer_irq rises on the clk_ms 2->3 edge and stays high until a cmp write.
- Assert clr mid-prescale, in the same cycle as a pending push -> FIFO empty, counters 0, next us tick exactly CLK_HZ/1e6 cycles after clr deasserts.
